power_meter_mc: RTL

Multi-channel mean-square power meter for the DSP measurement path. It samples CH parallel ADC channels on rising edges of the sample clock clk_samp. Each channel squares its samples and accumulates a runtime-selectable window of 2^win_log2 samples, then presents the normalised mean-square per channel and the window's peak absolute value through a valid/ready output. It runs either single-shot or continuously, and sits between the ADC capture logic and the measurement register bank.

---
 rtl/pm_pkg.sv | 23 ++
 rtl/power_meter_mc_if.sv | 21 ++
 rtl/pm_channel.sv | 88 ++++++++
 rtl/power_meter_mc.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/pm_pkg.sv
// Shared definitions for the multi-channel power meter.
//   pm_state_e : measurement FSM states
//   acc_width  : accumulator width needed for a window of 2^win_log2_max squares
//   clamp_win  : limits a requested window exponent to 1..w_max
package pm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } pm_state_e;

  function automatic int acc_width(input int data_w, input int win_log2_max);
    return 2 * data_w + win_log2_max;
  endfunction

  function automatic logic [3:0] clamp_win(input logic [3:0] w, input logic [3:0] w_max);
    if (w == 4'd0) return 4'd1;
    if (w > w_max) return w_max;
    return w;
  endfunction

endpackage

// File: rtl/power_meter_mc_if.sv
// Result channel of the power meter (valid/ready).
//   out_valid : result available          (master -> slave)
//   out_ready : consumer accepts result   (slave -> master)
//   out_msq   : CH x 2*DATA_W mean-square, channel c at [c*2*DATA_W +: 2*DATA_W]
//   out_peak  : CH x DATA_W peak |x|,      channel c at [c*DATA_W +: DATA_W]
interface power_meter_mc_if
  import pm_pkg::*;
#(
  parameter int CH     = 2,
  parameter int DATA_W = 12
) ();

  logic                     out_valid;
  logic                     out_ready;
  logic [CH*2*DATA_W-1:0]   out_msq;
  logic [CH*DATA_W-1:0]     out_peak;

  modport master (output out_valid, output out_msq, output out_peak, input out_ready);
  modport slave  (input out_valid, input out_msq, input out_peak, output out_ready);

endinterface

// File: rtl/pm_channel.sv
// One measurement channel: input register, squarer, accumulator, peak tracker.
//   ad_data  : this channel's ADC sample
//   cap_en   : register ad_data into stage p0
//   vld_p1   : stage p1 holds a sample to fold into the accumulator
//   clr      : zero accumulator and peak (wins over a concurrent fold)
//   win_q    : window exponent used to normalise the mean-square
//   msq_nxt  : mean-square including the sample being folded this cycle
//   peak_nxt : peak including the sample being folded this cycle
module pm_channel
  import pm_pkg::*;
#(
  parameter int DATA_W       = 12,
  parameter int WIN_LOG2_MAX = 12,
  parameter bit SIGNED       = 1'b1
) (
  input  logic                  clk_sys,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     ad_data,
  input  logic                  cap_en,
  input  logic                  vld_p1,
  input  logic                  clr,
  input  logic [3:0]            win_q,
  output logic [2*DATA_W-1:0]   msq_nxt,
  output logic [DATA_W-1:0]     peak_nxt
);

  localparam int ACC_W = acc_width(DATA_W, WIN_LOG2_MAX);
  localparam int MSQ_W = 2 * DATA_W;

  logic [DATA_W-1:0] x_p0;
  logic [MSQ_W-1:0]  sq_p1;
  logic [DATA_W-1:0] mag_p1;
  logic [ACC_W-1:0]  acc_p2;
  logic [DATA_W-1:0] peak_p2;
  logic [ACC_W-1:0]  acc_sum;

  // Low 2*DATA_W bits of the product are exact: the largest square is 2^(2*DATA_W-2).
  function automatic logic [MSQ_W-1:0] square(input logic [DATA_W-1:0] x);
    logic signed [MSQ_W-1:0] xs;
    logic [MSQ_W-1:0]        xu;
    if (SIGNED) begin
      xs = {{DATA_W{x[DATA_W-1]}}, x};
      return $unsigned(xs * xs);
    end
    xu = {{DATA_W{1'b0}}, x};
    return xu * xu;
  endfunction

  // Negating the most negative code yields 2^(DATA_W-1), which is correct read as unsigned.
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] x);
    if (SIGNED && x[DATA_W-1]) return -x;
    return x;
  endfunction

  // p0: sample capture
  always_ff @(posedge clk_sys) begin
    if (cap_en) x_p0 <= ad_data;
  end

  // p1: square and magnitude
  always_ff @(posedge clk_sys) begin
    sq_p1  <= square(x_p0);
    mag_p1 <= magnitude(x_p0);
  end

  // p2: accumulate and track peak
  always_comb begin
    acc_sum  = acc_p2;
    peak_nxt = peak_p2;
    if (vld_p1) begin
      acc_sum = acc_p2 + ACC_W'(sq_p1);
      if (mag_p1 > peak_p2) peak_nxt = mag_p1;
    end
  end

  assign msq_nxt = MSQ_W'(acc_sum >> win_q);

  always_ff @(posedge clk_sys) begin
    if (!rst_n || clr) begin
      acc_p2  <= '0;
      peak_p2 <= '0;
    end else begin
      acc_p2  <= acc_sum;
      peak_p2 <= peak_nxt;
    end
  end

endmodule

// File: rtl/power_meter_mc.sv
// Multi-channel mean-square power meter.
//   clk_sys, rst_n : system clock, synchronous active-low reset
//   clk_samp       : sample clock (asynchronous, period >= 4 clk_sys)
//   ad_data        : CH samples, channel c at [c*DATA_W +: DATA_W]
//   start/stop     : one-cycle pulses; stop wins
//   cont, win_log2 : continuous mode and window exponent, latched at start
//   busy           : measurement in RUN or FLUSH
//   overrun        : sticky, an unread result was overwritten
//   res            : result valid/ready channel (mean-square and peak)
module power_meter_mc
  import pm_pkg::*;
#(
  parameter int DATA_W       = 12,
  parameter int CH           = 2,
  parameter bit SIGNED       = 1'b1,
  parameter int WIN_LOG2_MAX = 12
) (
  input  logic                 clk_sys,
  input  logic                 rst_n,
  input  logic                 clk_samp,
  input  logic [CH*DATA_W-1:0] ad_data,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 cont,
  input  logic [3:0]           win_log2,
  output logic                 busy,
  output logic                 overrun,
  power_meter_mc_if.master     res
);

  localparam int         CNT_W = WIN_LOG2_MAX + 1;
  localparam logic [3:0] WMAX  = 4'(WIN_LOG2_MAX);

  pm_state_e state, state_nxt;

  logic                   samp_s1, samp_s2, samp_s3, samp_stb;
  logic                   cont_q;
  logic [3:0]             win_q;
  logic [CNT_W-1:0]       cnt, win_last;
  logic                   flush_2nd;
  logic                   cap_en, vld_p0, vld_p1, clr, publish, go_run, last_stb;
  logic                   valid_q;
  logic [CH*2*DATA_W-1:0] msq_nxt, msq_q;
  logic [CH*DATA_W-1:0]   peak_nxt, peak_q;

  // Two-flop synchroniser followed by a rising-edge detect.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      samp_s1 <= 1'b0;
      samp_s2 <= 1'b0;
      samp_s3 <= 1'b0;
    end else begin
      samp_s1 <= clk_samp;
      samp_s2 <= samp_s1;
      samp_s3 <= samp_s2;
    end
  end
  assign samp_stb = samp_s2 & ~samp_s3;

  assign win_last = (CNT_W'(1) << win_q) - CNT_W'(1);
  assign last_stb = (state == RUN) && samp_stb && (cnt == win_last);

  always_comb begin
    state_nxt = state;
    publish   = 1'b0;
    go_run    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_nxt = RUN;
          go_run    = 1'b1;
        end
      end
      RUN: begin
        if (stop)          state_nxt = IDLE;
        else if (last_stb) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (flush_2nd) begin
          publish   = 1'b1;
          state_nxt = cont_q ? RUN : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state     <= IDLE;
      flush_2nd <= 1'b0;
      cont_q    <= 1'b0;
      win_q     <= 4'd1;
    end else begin
      state     <= state_nxt;
      flush_2nd <= (state == FLUSH) && (state_nxt == FLUSH);
      if (go_run) begin
        cont_q <= cont;
        win_q  <= clamp_win(win_log2, WMAX);
      end
    end
  end

  // In continuous mode strobes landing in FLUSH already belong to the next window.
  assign cap_en = samp_stb && !stop && ((state == RUN) || ((state == FLUSH) && cont_q));
  // The accumulators restart on a continuous publish; the sample folded at that
  // edge is the old window's last one and is already inside msq_nxt.
  assign clr    = go_run || (publish && cont_q);

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      cnt    <= '0;
    end else begin
      vld_p0 <= cap_en;
      vld_p1 <= vld_p0 && !stop && (state != IDLE);
      if (go_run || stop) cnt <= '0;
      else if (cap_en)    cnt <= last_stb ? '0 : cnt + 1'b1;
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    pm_channel #(
      .DATA_W      (DATA_W),
      .WIN_LOG2_MAX(WIN_LOG2_MAX),
      .SIGNED      (SIGNED)
    ) u_ch (
      .clk_sys (clk_sys),
      .rst_n   (rst_n),
      .ad_data (ad_data[c*DATA_W +: DATA_W]),
      .cap_en  (cap_en),
      .vld_p1  (vld_p1),
      .clr     (clr),
      .win_q   (win_q),
      .msq_nxt (msq_nxt[c*2*DATA_W +: 2*DATA_W]),
      .peak_nxt(peak_nxt[c*DATA_W +: DATA_W])
    );
  end

  // A publish always lands; a pending unread result is overwritten and flagged.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      msq_q   <= '0;
      peak_q  <= '0;
      overrun <= 1'b0;
    end else begin
      if (publish) begin
        msq_q   <= msq_nxt;
        peak_q  <= peak_nxt;
        valid_q <= 1'b1;
        if (valid_q && !res.out_ready) overrun <= 1'b1;
      end else if (valid_q && res.out_ready) begin
        valid_q <= 1'b0;
      end
      if (go_run) overrun <= 1'b0;
    end
  end

  assign res.out_valid = valid_q;
  assign res.out_msq   = msq_q;
  assign res.out_peak  = peak_q;
  assign busy          = (state == RUN) || (state == FLUSH);

endmodule
